// File: rtl/sid_write_sequencer_if.sv
// Byte-stream handshake from the UART receiver into the SID write sequencer.
interface sid_write_sequencer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sid_write_sequencer.sv
// Parses host bytes into SID register writes / timed waits, buffers them in a FIFO
// and replays at most one entry per clk_en tick to the SID register port.
module sid_write_sequencer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sid_write_sequencer_if.slave s,
    input  logic                 clk_en,
    output logic [4:0]           sid_addr,
    output logic [7:0]           sid_data,
    output logic                 sid_n_cs,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic       is_wait;
        logic [4:0] addr;
        logic [7:0] data;
    } entry_t;

    typedef enum logic {P_ADDR, P_DATA} p_state_t;
    typedef enum logic {I_IDLE, I_WAIT} i_state_t;

    p_state_t       p_state, p_state_nxt;
    i_state_t       i_state, i_state_nxt;
    logic [4:0]     pend_addr;
    logic [6:0]     wait_cnt;
    entry_t         mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    entry_t         head;
    entry_t         push_entry;
    logic           consume, push, pop, full, empty;
    logic           load_wait, dec_wait, issue_write;

    assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty    = (fifo_level == '0);
    assign s.tready = ~full;
    assign consume  = s.tvalid & ~full;
    assign head     = mem[rd_ptr];
    assign busy     = ~empty | (wait_cnt != 7'd0) | ~sid_n_cs;

    // Parser: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p_state <= P_ADDR;
        else     p_state <= p_state_nxt;
    end

    // Parser: next state
    always_comb begin
        p_state_nxt = p_state;
        if (consume) begin
            case (p_state)
                P_ADDR:  if (s.tdata[7:5] == 3'd0) p_state_nxt = P_DATA;
                P_DATA:  p_state_nxt = P_ADDR;
                default: p_state_nxt = P_ADDR;
            endcase
        end
    end

    // Parser: enqueue decode
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (consume) begin
            case (p_state)
                P_ADDR: if (s.tdata[7]) begin
                    push       = 1'b1;
                    push_entry = '{is_wait: 1'b1, addr: 5'd0, data: {1'b0, s.tdata[6:0]}};
                end
                P_DATA: begin
                    push       = 1'b1;
                    push_entry = '{is_wait: 1'b0, addr: pend_addr, data: s.tdata};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend_addr <= 5'd0;
        else if (consume && p_state == P_ADDR && s.tdata[7:5] == 3'd0)
            pend_addr <= s.tdata[4:0];
    end

    // FIFO storage needs no reset; validity is tracked by the level
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // Issue: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) i_state <= I_IDLE;
        else     i_state <= i_state_nxt;
    end

    // Issue: next state; a zero-length wait never leaves I_IDLE
    always_comb begin
        i_state_nxt = i_state;
        case (i_state)
            I_IDLE: if (clk_en && !empty && head.is_wait && head.data[6:0] != 7'd0)
                        i_state_nxt = I_WAIT;
            I_WAIT: if (clk_en && wait_cnt == 7'd1)
                        i_state_nxt = I_IDLE;
            default: i_state_nxt = I_IDLE;
        endcase
    end

    // Issue: per-tick actions
    always_comb begin
        pop         = 1'b0;
        load_wait   = 1'b0;
        dec_wait    = 1'b0;
        issue_write = 1'b0;
        case (i_state)
            I_IDLE: if (clk_en && !empty) begin
                pop = 1'b1;
                if (head.is_wait) load_wait   = 1'b1;
                else              issue_write = 1'b1;
            end
            I_WAIT: if (clk_en) dec_wait = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 7'd0;
            sid_addr <= 5'd0;
            sid_data <= 8'd0;
            sid_n_cs <= 1'b1;
        end else begin
            if (load_wait)     wait_cnt <= head.data[6:0];
            else if (dec_wait) wait_cnt <= wait_cnt - 7'd1;
            sid_n_cs <= ~issue_write;
            if (issue_write) begin
                sid_addr <= head.addr;
                sid_data <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Randomised + directed bench for sid_write_sequencer against a queue/tick-count model.
module tb_sid_write_sequencer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b0;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       sid_n_cs;
    logic [4:0] fifo_level;
    logic       busy;

    sid_write_sequencer_if sif ();

    sid_write_sequencer #(.FIFO_DEPTH(16), .LVL_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (sif),
        .clk_en     (clk_en),
        .sid_addr   (sid_addr),
        .sid_data   (sid_data),
        .sid_n_cs   (sid_n_cs),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // Model: command queue, pending-address flag, and the tick index before which no pop may happen
    logic [13:0] mq[$];
    bit          m_have   = 1'b0;
    logic [4:0]  m_paddr  = 5'd0;
    int          m_ticks  = 0;
    int          m_next_ok = 0;
    bit          m_ncs    = 1'b1;
    logic [4:0]  m_addr   = 5'd0;
    logic [7:0]  m_data   = 8'd0;

    always @(posedge clk or posedge rst) begin : model
        bit          ready;
        logic [13:0] e;
        if (rst) begin
            mq.delete();
            m_have = 0; m_paddr = 0; m_ticks = 0; m_next_ok = 0;
            m_ncs = 1; m_addr = 0; m_data = 0;
        end else begin
            ready = (mq.size() < DEPTH);
            m_ncs = 1;
            if (clk_en) begin
                m_ticks++;
                if (m_ticks >= m_next_ok && mq.size() > 0) begin
                    e = mq.pop_front();
                    if (e[13]) m_next_ok = m_ticks + int'(e[6:0]) + 1;
                    else begin
                        m_ncs  = 0;
                        m_addr = e[12:8];
                        m_data = e[7:0];
                    end
                end
            end
            if (sif.tvalid && ready) begin
                if (!m_have) begin
                    if (sif.tdata < 8'h20) begin
                        m_have  = 1;
                        m_paddr = sif.tdata[4:0];
                    end else if (sif.tdata >= 8'h80)
                        mq.push_back({1'b1, 5'd0, 1'b0, sif.tdata[6:0]});
                end else begin
                    mq.push_back({1'b0, m_paddr, sif.tdata});
                    m_have = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("sid_n_cs",   32'(sid_n_cs),   32'(m_ncs));
        chk("sid_addr",   32'(sid_addr),   32'(m_addr));
        chk("sid_data",   32'(sid_data),   32'(m_data));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("busy",       32'(busy),
            32'(mq.size() != 0 || (m_next_ok - 1 > m_ticks) || !m_ncs));
        chk("s_tready",   32'(sif.tready), 32'(mq.size() < DEPTH));
    end

    typedef struct { int t; logic [4:0] a; logic [7:0] d; } wr_t;
    wr_t wr_log[$];
    int  tb_ticks = 0;

    always @(posedge clk) if (clk_en) tb_ticks <= tb_ticks + 1;

    always @(negedge clk) begin
        wr_t w;
        if (!rst && sid_n_cs === 1'b0) begin
            w.t = tb_ticks; w.a = sid_addr; w.d = sid_data;
            wr_log.push_back(w);
        end
    end

    int en_period = 0;
    int en_cnt    = 0;

    // Advance one clock; clk_en is either periodic or a one-shot set by the caller
    task automatic step();
        @(posedge clk);
        #2;
        if (en_period > 0) begin
            en_cnt++;
            clk_en = ((en_cnt % en_period) == 0);
        end else
            clk_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        sif.tdata  = b;
        sif.tvalid = 1'b1;
        n = 0;
        while (!sif.tready && n < 400) begin
            step();
            n++;
        end
        if (!sif.tready) timeout("send");
        else step();
        sif.tvalid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || fifo_level != 0) && n < bound) begin
            step();
            n++;
        end
        if (busy || fifo_level != 0) timeout("wait_idle");
    endtask

    initial begin
        sif.tvalid = 1'b0;
        sif.tdata  = 8'h00;
        #1 rst = 1'b1;
        step(); step();
        chk("rst_ncs",    32'(sid_n_cs),   32'd1);
        chk("rst_level",  32'(fifo_level), 32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_tready", 32'(sif.tready), 32'd1);
        chk("rst_addr",   32'(sid_addr),   32'd0);
        rst = 1'b0;
        en_period = 50;

        // Single write
        wr_log.delete();
        send(8'h18); send(8'h0F);
        wait_idle(500);
        chk("t1_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() >= 1) begin
            chk("t1_addr", 32'(wr_log[0].a), 32'h18);
            chk("t1_data", 32'(wr_log[0].d), 32'h0F);
        end
        chk("t1_level", 32'(fifo_level), 32'd0);

        // Resync bytes discarded
        wr_log.delete();
        send(8'h20); send(8'h55); send(8'h01); send(8'h10);
        wait_idle(500);
        chk("t2_count", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() >= 1) begin
            chk("t2_addr", 32'(wr_log[0].a), 32'h01);
            chk("t2_data", 32'(wr_log[0].d), 32'h10);
        end

        // Wait of 3 ticks between writes
        wr_log.delete();
        send(8'h00); send(8'hAA); send(8'h83); send(8'h01); send(8'hBB);
        wait_idle(1000);
        chk("t3_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            chk("t3_d0",  32'(wr_log[0].d), 32'hAA);
            chk("t3_a1",  32'(wr_log[1].a), 32'h01);
            chk("t3_d1",  32'(wr_log[1].d), 32'hBB);
            chk("t3_gap", 32'(wr_log[1].t - wr_log[0].t), 32'd5);
        end

        // Fill the FIFO with ticks stopped, then drain
        wr_log.delete();
        en_period = 0;
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            send(8'(i * 7 + 3));
        end
        step();
        chk("t4_level_full", 32'(fifo_level), 32'd16);
        chk("t4_tready_full", 32'(sif.tready), 32'd0);
        en_period = 50;
        en_cnt = 0;
        send(8'h10);
        send(8'(16 * 7 + 3));
        wait_idle(3000);
        chk("t4_count", 32'(wr_log.size()), 32'd17);
        if (wr_log.size() == 17) begin
            for (int i = 0; i < 17; i++) begin
                chk("t4_addr", 32'(wr_log[i].a), 32'(i));
                chk("t4_data", 32'(wr_log[i].d), 32'(8'(i * 7 + 3)));
            end
        end

        // Reset while waiting with entries queued
        wr_log.delete();
        en_period = 0;
        send(8'h85);
        send(8'h01); send(8'h11);
        send(8'h02); send(8'h22);
        send(8'h03); send(8'h33);
        clk_en = 1'b1;
        step();
        chk("t5_level_pre", 32'(fifo_level), 32'd3);
        chk("t5_busy_pre",  32'(busy),       32'd1);
        rst = 1'b1;
        #1;
        chk("t5_ncs",    32'(sid_n_cs),   32'd1);
        chk("t5_level",  32'(fifo_level), 32'd0);
        chk("t5_busy",   32'(busy),       32'd0);
        chk("t5_tready", 32'(sif.tready), 32'd1);
        step();
        rst = 1'b0;
        send(8'h05);
        step();
        chk("t5_addr_only", 32'(fifo_level), 32'd0);
        send(8'h07);
        step();
        chk("t5_after_data", 32'(fifo_level), 32'd1);

        // Push and pop on the same cycle
        send(8'h09);
        clk_en     = 1'b1;
        sif.tdata  = 8'h99;
        sif.tvalid = 1'b1;
        step();
        sif.tvalid = 1'b0;
        chk("t6_level", 32'(fifo_level), 32'd1);
        en_period = 50;
        wait_idle(500);
        chk("t6_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            chk("t6_a0", 32'(wr_log[0].a), 32'h05);
            chk("t6_d0", 32'(wr_log[0].d), 32'h07);
            chk("t6_a1", 32'(wr_log[1].a), 32'h09);
            chk("t6_d1", 32'(wr_log[1].d), 32'h99);
        end

        // Random traffic, varying tick rate, one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (i % 200 == 0) en_period = $urandom_range(1, 6);
            if (i == 1500) rst = 1'b1;
            if (i == 1502) rst = 1'b0;
            r = $urandom_range(0, 9);
            sif.tvalid = ($urandom_range(0, 2) != 0);
            if (r < 4)      sif.tdata = 8'($urandom_range(0, 31));
            else if (r < 7) sif.tdata = 8'($urandom_range(0, 255));
            else if (r < 8) sif.tdata = 8'($urandom_range(8'h80, 8'h84));
            else            sif.tdata = 8'($urandom_range(8'h20, 8'h7F));
            step();
        end
        sif.tvalid = 1'b0;
        en_period = 2;
        wait_idle(4000);
        chk("final_level", 32'(fifo_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
